instr_fetch: RTL and testbench

//  Instruction fetch/issue stage: owns the PC, reads instruction memory and presents
//  one 32-bit encoding at a time to the decode stage (in_encode/alu_control/is_halt).
//  It is the producer end of the encode interface. It stops fetching after it issues
//  the HALT encoding, and it accepts PC redirects from later stages.

---
 rtl/instr_fetch.sv | 116 +++++++++++
 tb/tb_instr_fetch.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch/issue stage: owns the PC, keeps at most one instruction-memory read
// in flight and hands one 32-bit encoding at a time to decode until HALT is issued.
module instr_fetch #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [31:0]       HALT_ENC = 32'h3F
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr_encode,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted,
    output logic [2:0]        fsm_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends combinationally on ready, and the payload is stable while valid waits.
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_WAIT   = 3'd1,
        S_HOLD   = 3'd2,
        S_DRAIN  = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_pc;
    logic              redir;

    // Once halted, redirects are ignored: only reset restarts fetch.
    assign redir = redirect_valid && (state != S_HALTED);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: begin
                if (imem_req_ready) begin
                    state_nxt = redir ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    state_nxt = redir ? S_FETCH : S_HOLD;
                end else if (redir) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (redir) begin
                    state_nxt = S_FETCH;
                end else if (instr_ready) begin
                    state_nxt = (instr_encode == HALT_ENC) ? S_HALTED : S_FETCH;
                end
            end
            S_DRAIN: begin
                if (imem_rsp_valid) begin
                    state_nxt = S_FETCH;
                end
            end
            S_HALTED: state_nxt = S_HALTED;
            default:  state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        imem_req_valid = (state == S_FETCH);
        instr_valid    = (state == S_HOLD);
        halted         = (state == S_HALTED);
        fsm_state      = state;
    end

    assign imem_req_addr = pc;

    // A redirect always wins the pc update, even over an accepted request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc           <= RESET_PC;
            req_pc       <= '0;
            instr_encode <= '0;
            instr_pc     <= '0;
        end else begin
            if (redir) begin
                pc <= redirect_pc & ~ADDR_W'(3);
            end else if (state == S_FETCH && imem_req_ready) begin
                pc <= pc + ADDR_W'(4);
            end
            if (state == S_FETCH && imem_req_ready) begin
                req_pc <= pc;
            end
            if (state == S_WAIT && imem_rsp_valid && !redir) begin
                instr_encode <= imem_rsp_data;
                instr_pc     <= req_pc;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a latency-configurable memory model, a decoder-side
// scoreboard monitor and directed scenarios covering issue, halt, stall, redirect, wrap, reset.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_encode;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;
    logic [2:0]  fsm_state;

    instr_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_encode   (instr_encode),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .fsm_state      (fsm_state)
    );

    // ---------------- clock / reset ----------------
    int cyc = 0;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- counters / scoreboard ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];
    int          hs_cyc[$];
    int          hs_count = 0;
    logic [31:0] addr_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- memory model ----------------
    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;
    rsp_t        mq[$];
    int          lat = 1;
    logic [31:0] mem_ovr [logic [31:0]];

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return a >> 2;
    endfunction

    // Acts just before each rising edge so its view matches what the DUT samples.
    initial begin
        rsp_t r;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            #4;
            if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
                r = mq.pop_front();
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = r.data;
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end
            if (rst && imem_req_valid && imem_req_ready) begin
                addr_log.push_back(imem_req_addr);
                r.due  = cyc + 1 + lat;
                r.data = mem_data(imem_req_addr);
                mq.push_back(r);
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #4;
            if (rst && instr_valid && instr_ready) begin
                hs_cyc.push_back(cyc + 1);
                hs_count++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_unexpected: got pc %h enc %h expected none", instr_pc, instr_encode);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", instr_pc, e[63:32]);
                    chk("sb_enc", instr_encode, e[31:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic reset_on();
        rst = 1'b0;
        addr_log.delete();
        hs_cyc.delete();
        hs_count = 0;
        step();
    endtask

    task automatic expect_issue(input logic [31:0] pc, input logic [31:0] enc);
        exp_q.push_back({pc, enc});
    endtask

    task automatic wait_hs(input int target, input string name);
        int n = 0;
        while (hs_count < target && n < 200) begin
            step();
            n++;
        end
        chk(name, 32'(hs_count >= target), 32'd1);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!instr_valid && n < 200) begin
            step();
            n++;
        end
        chk(name, {31'd0, instr_valid}, 32'd1);
    endtask

    task automatic wait_req(input int target, input string name);
        int n = 0;
        while (addr_log.size() < target && n < 200) begin
            step();
            n++;
        end
        chk(name, 32'(addr_log.size() >= target), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int reqs;
        rst            = 1'b0;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        step();
        step();
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_enc", instr_encode, 32'd0);
        chk("rst_pc", instr_pc, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_addr", imem_req_addr, 32'd0);

        // 1: back-to-back issue, 3-cycle interval
        instr_ready = 1'b1;
        expect_issue(32'h0, 32'h0);
        expect_issue(32'h4, 32'h1);
        expect_issue(32'h8, 32'h2);
        rst = 1'b1;
        wait_hs(3, "t1_done");
        chk("t1_addr0", addr_log[0], 32'h0);
        chk("t1_addr1", addr_log[1], 32'h4);
        chk("t1_addr2", addr_log[2], 32'h8);
        chk("t1_gap0", 32'(hs_cyc[1] - hs_cyc[0]), 32'd3);
        chk("t1_gap1", 32'(hs_cyc[2] - hs_cyc[1]), 32'd3);

        // 2: HALT stops fetch; redirects ignored afterwards
        reset_on();
        mem_ovr[32'h8] = 32'h3F;
        expect_issue(32'h0, 32'h0);
        expect_issue(32'h4, 32'h1);
        expect_issue(32'h8, 32'h3F);
        rst = 1'b1;
        wait_hs(3, "t2_done");
        chk("t2_halted", {31'd0, halted}, 32'd1);
        reqs = 0;
        for (int i = 0; i < 20; i++) begin
            redirect_valid = (i == 5);
            redirect_pc    = 32'h40;
            step();
            if (imem_req_valid) reqs++;
        end
        redirect_valid = 1'b0;
        chk("t2_no_req", 32'(reqs), 32'd0);
        chk("t2_req_count", 32'(addr_log.size()), 32'd3);
        chk("t2_still_halted", {31'd0, halted}, 32'd1);
        mem_ovr.delete();
        rst = 1'b0;
        #1;
        chk("t2_rst_halted", {31'd0, halted}, 32'd0);

        // 3: decoder stall holds outputs and blocks new requests
        reset_on();
        instr_ready = 1'b0;
        expect_issue(32'h0, 32'h0);
        expect_issue(32'h4, 32'h1);
        rst = 1'b1;
        wait_valid("t3_valid");
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_hold_valid", {31'd0, instr_valid}, 32'd1);
            chk("t3_hold_enc", instr_encode, 32'h0);
            chk("t3_hold_pc", instr_pc, 32'h0);
            chk("t3_no_req", {31'd0, imem_req_valid}, 32'd0);
        end
        chk("t3_req_count", 32'(addr_log.size()), 32'd1);
        instr_ready = 1'b1;
        wait_hs(2, "t3_done");

        // 4: redirect in WAIT, late response dropped
        reset_on();
        lat = 3;
        expect_issue(32'h100, 32'h40);
        rst = 1'b1;
        wait_req(1, "t4_first_req");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        step();
        redirect_valid = 1'b0;
        lat = 1;
        wait_hs(1, "t4_done");
        chk("t4_addr1", addr_log[1], 32'h100);

        // 5: redirect beats HALT in the same cycle as consumption
        reset_on();
        mem_ovr[32'h0] = 32'h3F;
        instr_ready = 1'b0;
        expect_issue(32'h0, 32'h3F);
        expect_issue(32'h200, 32'h80);
        rst = 1'b1;
        wait_valid("t5_valid");
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step();
        redirect_valid = 1'b0;
        chk("t5_not_halted", {31'd0, halted}, 32'd0);
        chk("t5_valid_drop", {31'd0, instr_valid}, 32'd0);
        wait_hs(2, "t5_done");
        chk("t5_addr1", addr_log[1], 32'h200);
        chk("t5_still_run", {31'd0, halted}, 32'd0);
        mem_ovr.delete();

        // 6: pc wrap, then reset mid-WAIT with a late response
        reset_on();
        mem_ovr[32'h0] = 32'hBAD0_0000;
        instr_ready    = 1'b1;
        expect_issue(32'hFFFF_FFFC, 32'h3FFF_FFFF);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        rst = 1'b1;
        step();
        redirect_valid = 1'b0;
        wait_hs(1, "t6_issue");
        lat = 4;
        step();
        chk("t6_req_count", 32'(addr_log.size()), 32'd3);
        chk("t6_wrap_addr", addr_log[2], 32'h0);
        rst            = 1'b0;
        imem_req_ready = 1'b0;
        #1;
        chk("t6_rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("t6_rst_enc", instr_encode, 32'd0);
        chk("t6_rst_pc", instr_pc, 32'd0);
        chk("t6_rst_req", {31'd0, imem_req_valid}, 32'd1);
        chk("t6_rst_addr", imem_req_addr, 32'd0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) step();
        mem_ovr.delete();
        lat = 1;
        imem_req_ready = 1'b1;
        hs_count = 0;
        expect_issue(32'h0, 32'h0);
        wait_hs(1, "t6_after_rst");

        step();
        step();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
